ptrgen: RTL

PTRGEN -- requirements
Module: ptrgen

---
 rtl/ptr_pkg.sv | 24 ++
 rtl/ptrgen_fsm.sv | 90 +++++++++
 rtl/ptrgen.sv | 81 ++++++++
 3 files changed

// File: rtl/ptr_pkg.sv
// Shared AU-4 pointer constants and frame-state encoding, common to the
// pointer generator and the pointer interpreter.
package ptr_pkg;
  localparam logic [3:0] NDF_NORM     = 4'b0110;
  localparam logic [3:0] NDF_EN       = 4'b1001;
  localparam logic [1:0] SS_AU4       = 2'b10;
  localparam logic [9:0] I_MASK       = 10'b10_1010_1010;
  localparam logic [9:0] D_MASK       = 10'b01_0101_0101;
  localparam logic [9:0] MAXOFFSET    = 10'd782;
  localparam logic [7:0] Y_BYTE       = 8'h9B;
  localparam logic [7:0] ONE_BYTE     = 8'hFF;
  localparam logic [7:0] H3_BYTE      = 8'h00;
  localparam logic [7:0] AIS_BYTE     = 8'hFF;
  localparam logic [3:0] NSLOT        = 4'd9;
  localparam logic [1:0] GUARD_FRAMES = 2'd3;

  typedef enum logic [2:0] {
    NORM = 3'd0,
    NDF  = 3'd1,
    INC  = 3'd2,
    DEC  = 3'd3,
    AIS  = 3'd4
  } state_t;
endpackage

// File: rtl/ptrgen_fsm.sv
// Frame-rate pointer state machine: request arbitration, guard window and
// offset arithmetic. Define PTRGEN_OFFSET_CHECK_EN to refuse out-of-range loads.
module ptrgen_fsm
  import ptr_pkg::*;
#(
  parameter logic [9:0] MAXOFFSET   = 10'd782,
  parameter logic [9:0] INIT_OFFSET = 10'd0
) (
  input  logic       clk19,
  input  logic       rst,
  input  logic       txsof,
  input  logic       load_req,
  input  logic       inc_req,
  input  logic       dec_req,
  input  logic       ais_req,
  input  logic [9:0] offset_in,
  output state_t     state,
  output logic [9:0] off,
  output logic       ack,
  output logic       rej
);
  state_t     state_n;
  logic [9:0] off_n, base;
  logic [1:0] guard, guard_n, guard_left;
  logic       ack_n, rej_n, load_ok;

  always_ff @(posedge clk19 or negedge rst) begin
    if (!rst) begin
      state <= NORM;
      off   <= INIT_OFFSET;
      guard <= 2'd0;
      ack   <= 1'b0;
      rej   <= 1'b0;
    end else begin
      state <= state_n;
      off   <= off_n;
      guard <= guard_n;
      ack   <= ack_n;
      rej   <= rej_n;
    end
  end

  always_comb begin
    state_n = state;
    off_n   = off;
    guard_n = guard;
    ack_n   = 1'b0;
    rej_n   = 1'b0;
    // a justification takes effect on the frame after the one that signalled it
    base = off;
    if (state == INC)      base = (off >= MAXOFFSET) ? 10'd0 : off + 10'd1;
    else if (state == DEC) base = (off == 10'd0) ? MAXOFFSET : off - 10'd1;
    guard_left = (guard != 2'd0) ? guard - 2'd1 : 2'd0;
`ifdef PTRGEN_OFFSET_CHECK_EN
    load_ok = (offset_in <= MAXOFFSET);
`else
    load_ok = 1'b1;
`endif
    if (txsof) begin
      state_n = NORM;
      off_n   = base;
      guard_n = guard_left;
      if (ais_req) begin
        state_n = AIS;
        guard_n = 2'd0;
        ack_n   = 1'b1;
      end else if (load_req && load_ok) begin
        state_n = NDF;
        off_n   = offset_in;
        guard_n = GUARD_FRAMES;
        ack_n   = 1'b1;
      end else if (state == AIS) begin
        // leaving AIS always re-announces the held offset with NDF
        state_n = NDF;
        guard_n = GUARD_FRAMES;
        rej_n   = load_req;
      end else if (load_req) begin
        rej_n = 1'b1;
      end else if (inc_req || dec_req) begin
        if ((guard != 2'd0) || (inc_req && dec_req)) begin
          rej_n = 1'b1;
        end else begin
          state_n = inc_req ? INC : DEC;
          guard_n = GUARD_FRAMES;
          ack_n   = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ptrgen.sv
// AU-4 pointer byte generator: FSM instance plus the nine-slot H1..H3 byte mux.
// Define PTRGEN_OFFSET_CHECK_EN to refuse load offsets above MAXOFFSET.
module ptrgen
  import ptr_pkg::*;
#(
  parameter logic [9:0] MAXOFFSET   = ptr_pkg::MAXOFFSET,
  parameter logic [9:0] INIT_OFFSET = 10'd0
) (
  input  logic       clk19,
  input  logic       rst,
  input  logic       txsof,
  input  logic       en,
  input  logic [9:0] offset_in,
  input  logic       load_req,
  input  logic       inc_req,
  input  logic       dec_req,
  input  logic       ais_req,
  output logic [7:0] dout,
  output logic [9:0] cur_offset,
  output logic       req_ack,
  output logic       req_rej,
  output logic       inc_frm,
  output logic       dec_frm
);
  state_t     state;
  logic [9:0] off, tx_off;
  logic [3:0] slot;
  logic [7:0] h1, h2, slot_byte;

  ptrgen_fsm #(.MAXOFFSET(MAXOFFSET), .INIT_OFFSET(INIT_OFFSET)) u_fsm (
    .clk19    (clk19),
    .rst      (rst),
    .txsof    (txsof),
    .load_req (load_req),
    .inc_req  (inc_req),
    .dec_req  (dec_req),
    .ais_req  (ais_req),
    .offset_in(offset_in),
    .state    (state),
    .off      (off),
    .ack      (req_ack),
    .rej      (req_rej)
  );

  always_comb begin
    tx_off = off;
    if (state == INC)      tx_off = off ^ I_MASK;
    else if (state == DEC) tx_off = off ^ D_MASK;
    h1 = {(state == NDF) ? NDF_EN : NDF_NORM, SS_AU4, tx_off[9:8]};
    h2 = tx_off[7:0];
    case (slot)
      4'd0:       slot_byte = h1;
      4'd1, 4'd2: slot_byte = Y_BYTE;
      4'd3:       slot_byte = h2;
      4'd4, 4'd5: slot_byte = ONE_BYTE;
      default:    slot_byte = H3_BYTE;
    endcase
    if (state == AIS) slot_byte = AIS_BYTE;
  end

  // txsof outranks en; surplus en pulses emit zero and park the counter
  always_ff @(posedge clk19 or negedge rst) begin
    if (!rst) begin
      slot <= 4'd0;
      dout <= 8'h00;
    end else if (txsof) begin
      slot <= 4'd0;
    end else if (en) begin
      if (slot < NSLOT) begin
        dout <= slot_byte;
        slot <= slot + 4'd1;
      end else begin
        dout <= 8'h00;
      end
    end
  end

  assign cur_offset = off;
  assign inc_frm    = (state == INC);
  assign dec_frm    = (state == DEC);
endmodule
